// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-source
// encoding used by the EX operand muxes.
package pipe_ctrl_pkg;

  // EX ALU operand source. 2'b11 is reserved and never driven.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,  // value read from the register file in ID
    FWD_WB  = 2'b01,  // value being written back this cycle
    FWD_MEM = 2'b10   // ALU result sitting in EX/MEM
  } fwd_e;

  localparam int FWD_W = 2;

endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// Forwarding source select for one EX ALU operand. The newest producer
// (MEM) wins over the older one (WB); register 0 is excluded by the caller
// through the *_wr qualifiers.
module pipe_ctrl_fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic            use_src,
  input  logic            mem_wr,
  input  logic [RA_W-1:0] mem_wreg,
  input  logic            wb_wr,
  input  logic [RA_W-1:0] wb_wreg,
  output fwd_e            sel
);

  // Pick the youngest in-flight producer of the operand, else the regfile.
  always_comb begin
    // NOTE: assign a default before any branch so every path drives sel and no latch is inferred.
    sel = FWD_REG;
    if (use_src && mem_wr && (mem_wreg == src)) begin
      sel = FWD_MEM;
    end else if (use_src && wb_wr && (wb_wreg == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline. Tracks the
// destinations of the instructions in EX, MEM and WB, and from them derives
// load-use stalls, taken-branch flushes, EX forwarding selects and the ID
// same-cycle write-back bypass. Counts stall cycles and flush events.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_regdst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             mem_br_taken,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             id_byp_a,
  output logic             id_byp_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Full shadow of the instruction in EX: it is the only slot whose sources
  // and load flag are still consulted (forwarding and load-use detection).
  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memread;
    logic [RA_W-1:0] wreg;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic            use_rs;
    logic            use_rt;
  } slot_t;

  slot_t           id_info;
  slot_t           ex_q;
  // MEM and WB are only ever asked "do you write, and which register", so
  // they keep just that pair; a bubble is simply a non-writing slot.
  logic            mem_wr_q;
  logic [RA_W-1:0] mem_wreg_q;
  logic            wb_wr_q;
  logic [RA_W-1:0] wb_wreg_q;

  logic            ex_wr;
  logic            flush;
  logic            stall;
  fwd_e            sel_a;
  fwd_e            sel_b;

  assign id_info = '{
    valid:    1'b1,
    regwrite: id_regwrite,
    memread:  id_memread,
    wreg:     id_regdst ? id_rd : id_rt,
    rs:       id_rs,
    rt:       id_rt,
    use_rs:   id_use_rs,
    use_rt:   id_use_rt
  };

  // A writer of register 0 is treated as not writing, so $0 never forwards or stalls.
  assign ex_wr = ex_q.valid && ex_q.regwrite && (ex_q.wreg != '0);
  assign flush = mem_br_taken;
  assign stall = ex_wr && ex_q.memread &&
                 ((id_use_rs && (id_rs == ex_q.wreg)) ||
                  (id_use_rt && (id_rt == ex_q.wreg)));

  // Advance the slots; a flush kills EX and MEM, a stall bubbles EX only.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every slot samples its pre-edge source.
    if (rst) begin
      ex_q       <= '0;
      mem_wr_q   <= 1'b0;
      mem_wreg_q <= '0;
      wb_wr_q    <= 1'b0;
      wb_wreg_q  <= '0;
    end else begin
      ex_q       <= (flush || stall) ? '0 : id_info;
      mem_wr_q   <= ex_wr && !flush;
      mem_wreg_q <= flush ? '0 : ex_q.wreg;
      wb_wr_q    <= mem_wr_q;
      wb_wreg_q  <= mem_wreg_q;
    end
  end

  // Performance counters; a stall masked by a flush is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !flush) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush)           flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Sequencing controls: flush overrides stall; everything idle in reset.
  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!rst) begin
      if (flush) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (stall) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  pipe_ctrl_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .src      (ex_q.rs),
    .use_src  (ex_q.use_rs),
    .mem_wr   (mem_wr_q),
    .mem_wreg (mem_wreg_q),
    .wb_wr    (wb_wr_q),
    .wb_wreg  (wb_wreg_q),
    .sel      (sel_a)
  );

  pipe_ctrl_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .src      (ex_q.rt),
    .use_src  (ex_q.use_rt),
    .mem_wr   (mem_wr_q),
    .mem_wreg (mem_wreg_q),
    .wb_wr    (wb_wr_q),
    .wb_wreg  (wb_wreg_q),
    .sel      (sel_b)
  );

  // Forwarding and ID bypass, held at the register-file path during reset.
  always_comb begin
    fwd_a    = rst ? FWD_REG : sel_a;
    fwd_b    = rst ? FWD_REG : sel_b;
    id_byp_a = !rst && wb_wr_q && id_use_rs && (wb_wreg_q == id_rs);
    id_byp_b = !rst && wb_wr_q && id_use_rt && (wb_wreg_q == id_rt);
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Keeps a shadow scoreboard of in-flight destination registers for the ID/EX, EX/MEM and MEM/WB slots.
- Generates PC/IF_ID write enables, stage flushes on a taken branch, load-use stalls, and EX-stage and ID-stage forwarding selects.
- Holds performance counters for stalls and flushes.

Parameters:
- RA_W, 5, register-address width.
- CNT_W, 32, width of the stall and flush counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- id_rs  in  RA_W  ID instruction rs field [25:21].
- id_rt  in  RA_W  ID instruction rt field [20:16].
- id_rd  in  RA_W  ID instruction rd field [15:11].
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_regdst  in  1  destination select: 1 = rd, 0 = rt.
- id_regwrite  in  1  ID instruction writes a register.
- id_memread  in  1  ID instruction is a load.
- mem_br_taken  in  1  MEM_Branch & MEM_zero.
- pc_we  out  1  PC write enable.
- if_id_we  out  1  IF_ID write enable.
- if_id_flush  out  1  load NOP into IF_ID.
- id_ex_flush  out  1  load bubble (all controls 0) into ID_EX.
- ex_mem_flush  out  1  load bubble into EX_MEM.
- fwd_a  out  2  EX ALU operand A source.
- fwd_b  out  2  EX ALU operand B source.
- id_byp_a  out  1  ID rdata1 takes the WB write data.
- id_byp_b  out  1  ID rdata2 takes the WB write data.
- stall_cnt  out  CNT_W  count of load-use stall cycles.
- flush_cnt  out  CNT_W  count of taken-branch flush events.

Behaviour:
- Slots: EX, MEM, WB. Each holds {valid, regwrite, memread, wreg, rs, rt, use_rs, use_rt}.
  - ID wreg = id_regdst ? id_rd : id_rt.
  - A slot is "writing" iff valid & regwrite & wreg != 0.
- Slot update on every posedge clk:
  - EX <= bubble if (flush | stall), else ID info.
  - MEM <= bubble if flush, else EX.
  - WB <= MEM.
- rst (sync): all slots invalid, both counters 0.
  - Outputs during and after reset: pc_we=1, if_id_we=1, all flushes=0, fwd_a=fwd_b=00, id_byp_a=id_byp_b=0.
  - Reset mid-operation discards all in-flight hazard state at that edge.
- flush = mem_br_taken. It asserts if_id_flush, id_ex_flush and ex_mem_flush combinationally in the same cycle, killing the three younger instructions. Branch penalty is 3 cycles.
- Load-use stall:
  - Condition: EX slot writing & EX.memread & ((id_use_rs & id_rs == EX.wreg) | (id_use_rt & id_rt == EX.wreg)).
  - Response: pc_we=0, if_id_we=0, id_ex_flush=1. Exactly one stall cycle per load-use pair.
- Priority: flush overrides stall.
  - With both true: pc_we=1, if_id_we=1, all three flushes=1.
  - stall_cnt does not increment; flush_cnt increments by 1.
- Forwarding (combinational from the slots, for the EX instruction). For fwd_a:
  - 10 if MEM writing & EX.use_rs & MEM.wreg == EX.rs.
  - else 01 if WB writing & EX.use_rs & WB.wreg == EX.rs.
  - else 00.
  - fwd_b is the same with rt / use_rt.
  - MEM has priority over WB, so the newest value wins.
  - Source 11 is reserved and never driven.
- ID bypass: id_byp_a = WB writing & id_use_rs & WB.wreg == id_rs. id_byp_b is the same with rt. This covers a register-file read in the same cycle as the write.
- Register 0: never forwarded, never stalls.
- Counters:
  - stall_cnt +1 on each cycle with stall & ~flush.
  - flush_cnt +1 on each cycle with flush.
  - Both wrap modulo 2^CNT_W.

Decomposition:
- Shared header mips_defs.vh: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, slot field widths.
- One sub-module fwd_sel, instanced twice (operand A and B).
  - Inputs: src reg, use, MEM writing/wreg, WB writing/wreg.
  - Output: 2-bit select.

Test Plan:
- rst high 2 cycles, then low with no hazards -> pc_we=1, if_id_we=1, fwd_a=fwd_b=00, counters 0.
- add $3,$1,$2 then sub $4,$3,$5 back-to-back -> sub in EX: fwd_a=10, fwd_b=00. Insert one NOP between them instead -> fwd_a=01.
- lw $2,0($0) then add $4,$2,$2 -> one cycle with pc_we=0, if_id_we=0, id_ex_flush=1; next cycle fwd_a=fwd_b=01; stall_cnt=1.
- beq taken (mem_br_taken=1 one cycle) -> if_id_flush=id_ex_flush=ex_mem_flush=1 that cycle; MEM slot invalid next cycle; flush_cnt=1.
- Load-use stall coincident with mem_br_taken -> no stall (pc_we=1), all flushes=1, stall_cnt unchanged.
- Writes to $0 followed by a reader of $0 -> no forward, no stall. Preload stall_cnt to 2^CNT_W-1 and stall once -> wraps to 0. rst during a stall -> next cycle pc_we=1, slots cleared.
